spi_tx_sequencer: RTL and testbench

- Avalon-MM slave that takes 16-bit words from the Nios and serialises them onto a mode-0 SPI link (CPOL=0, CPHA=0, MSB first) toward the DSP.
- Sits beside the TX PIO register and adds what the PIO lacks: a small TX FIFO, a programmable SCLK divider, chip-select framing, status flags and an idle interrupt.

---
 rtl/spi_tx_sequencer.sv | 162 ++++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sequencer.sv
// Avalon-MM TX FIFO feeding a mode-0 SPI master (MSB first) with chip-select framing and an idle interrupt.
// Frames are 35*(clk_div+1) clocks long; a full FIFO drops new words and sets overflow; SPI_TX_FRAME_COUNT_EN adds a frame counter.
module spi_tx_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int TW    = $clog2(2 * DATA_W);

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DIV_W-1:0]  clk_div, half_div, cnt;
  logic              enable, irq_en, overflow;
  logic [DATA_W-1:0] shreg;
  logic [TW-1:0]     tog;
  logic              sclk_q;
  logic              wr, push, push_ok, full, empty, pop, last_h;
  logic              unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign push         = wr & (address == 2'd0);
  assign full         = (level == LVL_W'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign push_ok      = push & ~full;
  assign pop          = (state == IDLE) & enable & ~empty;
  assign last_h       = (cnt == half_div);
  assign unused_wdata = ^writedata[31:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = LEAD;
      LEAD:    if (last_h) state_next = SHIFT;
      SHIFT:   if (last_h && tog == TW'(2 * DATA_W - 1)) state_next = TRAIL;
      TRAIL:   if (last_h) state_next = GAP;
      GAP:     if (last_h) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n = 1'b1;
    spi_sclk = sclk_q;
    spi_mosi = shreg[DATA_W-1];
    if (state == LEAD || state == SHIFT || state == TRAIL) spi_cs_n = 1'b0;
  end

  // cnt walks 0..half_div in every non-idle state; each wrap is either a state change or an SCLK toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      half_div <= '0;
      tog      <= '0;
      sclk_q   <= 1'b0;
      shreg    <= '0;
    end else begin
      if (state == IDLE || last_h) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (pop) begin
        shreg    <= mem[rd_ptr];
        half_div <= clk_div;
        tog      <= '0;
      end else if (state == SHIFT && last_h) begin
        sclk_q <= ~sclk_q;
        tog    <= tog + 1'b1;
        if (sclk_q) shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push_ok) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_div  <= DIV_W'(4);
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr && address == 2'd2) begin
        clk_div <= writedata[DIV_W-1:0];
        enable  <= writedata[8];
        irq_en  <= writedata[9];
      end
      if (push && full)                              overflow <= 1'b1;
      else if (wr && address == 2'd1 && writedata[3]) overflow <= 1'b0;
      irq <= irq_en & (state == IDLE) & empty;
    end
  end

`ifdef SPI_TX_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                  frame_cnt <= '0;
    else if (wr && address == 2'd3)             frame_cnt <= '0;
    else if (state == GAP && state_next == IDLE) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd1: begin
        readdata[0]          = ~empty | (state != IDLE);
        readdata[1]          = full;
        readdata[2]          = empty;
        readdata[3]          = overflow;
        readdata[4 +: LVL_W] = level;
      end
      2'd2: begin
        readdata[DIV_W-1:0] = clk_div;
        readdata[8]         = enable;
        readdata[9]         = irq_en;
      end
`ifdef SPI_TX_FRAME_COUNT_EN
      2'd3: readdata[15:0] = frame_cnt;
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Bench for spi_tx_sequencer: directed steps plus randomized bursts against a queue-based frame model.
module tb_spi_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        spi_sclk, spi_mosi, spi_cs_n, irq;

  int tests = 0;
  int fails = 0;

  spi_tx_sequencer dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Link monitor: one record per chip-select window
  typedef struct {
    logic [15:0] dat;
    int          rises;
    int          lows;
    int          fall_t;
  } frame_t;

  frame_t      frm_q[$];
  frame_t      mon_f;
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] mon_sh;
  int          mon_rises, mon_lows, mon_fall;

  always @(negedge clk) begin
    cyc++;
    if (spi_cs_n === 1'b0) begin
      if (prev_cs === 1'b1) begin
        mon_sh = '0; mon_rises = 0; mon_lows = 0; mon_fall = cyc;
      end
      mon_lows++;
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
        mon_sh = {mon_sh[14:0], spi_mosi};
        mon_rises++;
      end
    end else if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
      mon_f.dat = mon_sh; mon_f.rises = mon_rises; mon_f.lows = mon_lows; mon_f.fall_t = mon_fall;
      frm_q.push_back(mon_f);
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  // Reference model: the FIFO is just a bounded queue plus a sticky overflow flag
  logic [15:0] model_q[$];
  bit          model_ovf = 1'b0;
  logic [31:0] rd;
  int          dv, nw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] status_word(input int lvl, input bit ovf);
    logic [2:0] l3;
    l3 = 3'(lvl);
    return {25'd0, l3, ovf, lvl == 0, lvl == 4, lvl != 0};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  task automatic push_word(input logic [15:0] d);
    bus_write(2'd0, {16'd0, d});
    if (model_q.size() < 4) model_q.push_back(d);
    else                    model_ovf = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frm_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_wait_timeout", frm_q.size() >= n, 1);
  endtask

  task automatic wait_pin(input string tag, input bit want_sclk, input logic val, input int budget);
    int t = 0;
    while (((want_sclk ? spi_sclk : spi_cs_n) !== val) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, want_sclk ? spi_sclk : spi_cs_n, val);
  endtask

  // Expects every queued model word to go out in order, spaced 35H+1 apart, then nothing more
  task automatic run_frames(input int h);
    int n;
    n = model_q.size();
    wait_frames(n, n * (35 * h + 2) + 40);
    for (int i = 0; i < n && i < frm_q.size(); i++) begin
      check($sformatf("frame%0d_data", i), frm_q[i].dat, model_q[i]);
      check($sformatf("frame%0d_rises", i), frm_q[i].rises, 16);
      check($sformatf("frame%0d_cs_low", i), frm_q[i].lows, 34 * h);
      if (i > 0) check($sformatf("frame%0d_period", i), frm_q[i].fall_t - frm_q[i-1].fall_t, 35 * h + 1);
    end
    repeat (35 * h + 10) @(negedge clk);
    check("no_extra_frames", frm_q.size(), n);
    bus_read(2'd1, rd);
    check("status_after_frames", rd, 32'h4);
    model_q.delete();
    frm_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    bus_read(2'd0, rd); check("reset_txdata", rd, 32'h0);
    bus_read(2'd1, rd); check("reset_status", rd, 32'h4);
    bus_read(2'd2, rd); check("reset_control", rd, 32'h4);
    bus_read(2'd3, rd); check("reset_addr3", rd, 32'h0);
    check("reset_cs_n", spi_cs_n, 1'b1);
    check("reset_sclk", spi_sclk, 1'b0);
    check("reset_mosi", spi_mosi, 1'b0);
    check("reset_irq", irq, 1'b0);

    // Single fastest frame
    bus_write(2'd2, 32'h100);
    push_word(16'hA5C3);
    run_frames(1);

    // Overflow with enable off, then drain four frames
    bus_write(2'd2, 32'h000);
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    bus_read(2'd1, rd); check("ovf_status_full", rd, status_word(model_q.size(), model_ovf));
    bus_write(2'd1, 32'h8);
    model_ovf = 1'b0;
    bus_read(2'd1, rd); check("ovf_status_cleared", rd, status_word(model_q.size(), model_ovf));
    bus_write(2'd2, 32'h100);
    run_frames(1);

    // Enable dropped and clk_div rewritten mid-frame: frame finishes at its latched rate
    bus_write(2'd2, 32'h003);
    push_word(16'h1234);
    push_word(16'hBEEF);
    bus_write(2'd2, 32'h103);
    wait_pin("midframe_sclk_high", 1'b1, 1'b1, 200);
    bus_write(2'd2, 32'h000);
    wait_frames(1, 300);
    if (frm_q.size() >= 1) begin
      check("midframe_data", frm_q[0].dat, 16'h1234);
      check("midframe_cs_low", frm_q[0].lows, 34 * 4);
    end
    repeat (20) @(negedge clk);
    check("midframe_no_second", frm_q.size(), 1);
    bus_read(2'd1, rd); check("midframe_status", rd, status_word(1, 1'b0));
    bus_write(2'd2, 32'h100);
    wait_frames(2, 100);
    if (frm_q.size() >= 2) begin
      check("second_data", frm_q[1].dat, 16'hBEEF);
      check("second_cs_low", frm_q[1].lows, 34);
    end
    model_q.delete();
    frm_q.delete();

    // Randomized bursts
    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(0, 3);
      nw = $urandom_range(1, 6);
      bus_write(2'd2, 32'(dv));
      for (int k = 0; k < nw; k++) push_word(16'($urandom));
      bus_read(2'd1, rd); check($sformatf("rand%0d_status", it), rd, status_word(model_q.size(), model_ovf));
      bus_write(2'd1, 32'h8);
      model_ovf = 1'b0;
      bus_read(2'd1, rd); check($sformatf("rand%0d_status_clr", it), rd, status_word(model_q.size(), model_ovf));
      bus_write(2'd2, 32'h100 | 32'(dv));
      run_frames(dv + 1);
    end

    // Idle interrupt
    bus_write(2'd2, 32'h300);
    @(negedge clk);
    check("irq_idle", irq, 1'b1);
    push_word(16'h5A5A);
    wait_pin("irq_frame_start", 1'b0, 1'b0, 20);
    check("irq_in_frame", irq, 1'b0);
    wait_pin("irq_frame_end", 1'b0, 1'b1, 100);
    check("irq_gap", irq, 1'b0);
    @(negedge clk);
    check("irq_idle_entry", irq, 1'b0);
    @(negedge clk);
    check("irq_after_idle", irq, 1'b1);
    if (frm_q.size() >= 1) check("irq_frame_data", frm_q[0].dat, 16'h5A5A);
    model_q.delete();
    frm_q.delete();

    // Reset in the middle of SHIFT
    push_word(16'hFFFF);
    wait_pin("rst_sclk_high", 1'b1, 1'b1, 50);
    reset = 1'b1;
    address = 2'd1;
    @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_status", readdata, 32'h4);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_q.delete();
    frm_q.delete();
    bus_read(2'd2, rd); check("rst_control", rd, 32'h4);

    // Frame counter at address 3
`ifdef SPI_TX_FRAME_COUNT_EN
    bus_write(2'd2, 32'h000);
    for (int i = 0; i < 3; i++) push_word(16'($urandom));
    bus_write(2'd2, 32'h100);
    run_frames(1);
    bus_read(2'd3, rd); check("frame_count", rd, 32'd3);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd); check("frame_count_clear", rd, 32'd0);
`else
    bus_write(2'd2, 32'h000);
    push_word(16'h0F0F);
    bus_write(2'd2, 32'h100);
    run_frames(1);
    bus_read(2'd3, rd); check("addr3_zero", rd, 32'd0);
    bus_write(2'd3, 32'hFFFF);
    bus_read(2'd3, rd); check("addr3_zero_after_write", rd, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
